// File: rtl/pec_act_feeder_pkg.sv
// Shared constants, FSM encoding and word+marker bundle sizing for the PEC activation feeder.
package pec_act_feeder_pkg;

  localparam int PEC_DATA_WIDTH    = 8;
  localparam int PEC_CHANNEL_DEPTH = 32;
  localparam int PEC_ADDR_WIDTH    = 10;
  localparam int PEC_CNT_WIDTH     = 8;

  // Stored word layout: {flags, data, frt, lst_row, lst_blk}
  localparam int PEC_BUNDLE_WIDTH = PEC_CHANNEL_DEPTH + PEC_DATA_WIDTH * PEC_CHANNEL_DEPTH + 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feeder_state_e;

  function automatic int bundle_width(input int dw, input int cd);
    return cd + dw * cd + 3;
  endfunction

endpackage

// File: rtl/pec_act_skid_buf.sv
// Two-entry FIFO holding fetched activation words; push and pop may occur in the same cycle.
module pec_act_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/pec_act_feeder.sv
// Head-of-chain activation transmitter: walks a block of buffer words, tags row/block markers,
// and offers them to the first PEC over a level-ready / pulse-get handshake.
module pec_act_feeder
  import pec_act_feeder_pkg::*;
#(
  parameter int DATA_WIDTH    = PEC_DATA_WIDTH,
  parameter int CHANNEL_DEPTH = PEC_CHANNEL_DEPTH,
  parameter int ADDR_WIDTH    = PEC_ADDR_WIDTH,
  parameter int CNT_WIDTH     = PEC_CNT_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_start,
  input  logic [ADDR_WIDTH-1:0]               cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]                cfg_row_len,
  input  logic [CNT_WIDTH-1:0]                cfg_row_num,
  output logic                                buf_rd_en,
  output logic [ADDR_WIDTH-1:0]               buf_rd_addr,
  input  logic [CHANNEL_DEPTH-1:0]            buf_rd_flg,
  input  logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] buf_rd_dat,
  output logic                                pec_rdy_act,
  input  logic                                pec_get_act,
  output logic [CHANNEL_DEPTH-1:0]            pec_flg_act,
  output logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] pec_act,
  output logic                                pec_frt_act_row,
  output logic                                pec_lst_act_row,
  output logic                                pec_lst_act_blk,
  output logic                                busy,
  output logic                                done,
  output logic                                err_get,
  output feeder_state_e                       dbg_state
);

  // Handshake: pec_rdy_act is a level meaning the head word is valid; pec_get_act is a one-cycle
  // pulse, and a word transfers only on an edge where both are high. A get without rdy is dropped.

  localparam int BW = bundle_width(DATA_WIDTH, CHANNEL_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  feeder_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0]   len_q, num_q, col_q, row_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   issue_end_q;
  logic                   inflight_q;
  logic [2:0]             mark_q;
  logic                   err_q;

  logic                   pop, issue, zero_cfg;
  logic                   frt, lst_row, lst_blk;
  logic [1:0]             occ;
  logic                   buf_empty, buf_full;
  logic [2:0]             occ_after;
  logic [BW-1:0]          head;

  assign zero_cfg  = (cfg_row_len == '0) || (cfg_row_num == '0);
  assign pop       = pec_get_act && pec_rdy_act;
  assign frt       = (col_q == '0);
  assign lst_row   = (col_q == len_q - CNT_ONE);
  assign lst_blk   = lst_row && (row_q == num_q - CNT_ONE);
  // Words held plus the read in flight, less any word leaving this cycle, must stay below two.
  assign occ_after = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == ST_RUN) && !issue_end_q && (occ_after < 3'd2);

  pec_act_skid_buf #(.WIDTH(BW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({buf_rd_flg, buf_rd_dat, mark_q}),
    .pop       (pop),
    .head      (head),
    .count     (occ),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cfg_start) state_d = zero_cfg ? ST_DONE : ST_RUN;
      ST_RUN:  if (pop && head[0]) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      num_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      issue_end_q <= 1'b0;
      inflight_q  <= 1'b0;
      mark_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (pec_get_act && !pec_rdy_act) err_q <= 1'b1;
      if (state_q == ST_IDLE && cfg_start && !zero_cfg) begin
        len_q       <= cfg_row_len;
        num_q       <= cfg_row_num;
        addr_q      <= cfg_base_addr;
        col_q       <= '0;
        row_q       <= '0;
        issue_end_q <= 1'b0;
      end else if (issue) begin
        addr_q <= addr_q + 1'b1;
        mark_q <= {frt, lst_row, lst_blk};
        if (lst_row) begin
          col_q <= '0;
          row_q <= row_q + CNT_ONE;
        end else begin
          col_q <= col_q + CNT_ONE;
        end
        if (lst_blk) issue_end_q <= 1'b1;
      end
    end
  end

  assign buf_rd_en       = issue;
  assign buf_rd_addr     = addr_q;
  assign pec_rdy_act     = !buf_empty;
  assign pec_flg_act     = head[BW-1 -: CHANNEL_DEPTH];
  assign pec_act         = head[3 +: DATA_WIDTH*CHANNEL_DEPTH];
  assign pec_frt_act_row = head[2];
  assign pec_lst_act_row = head[1];
  assign pec_lst_act_blk = head[0];
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign err_get         = err_q;
  assign dbg_state       = state_q;

endmodule
